// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register, stall/redirect/fault handling.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
module fetch_stage #(
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned INSTRUCTIONWIDTH = 24,
    parameter int unsigned PC_STEP          = 2,
    parameter int unsigned IMEM_BYTES       = 32,
    parameter int unsigned RESET_PC         = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [WIDTH-1:0]            imem_addr,
    input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [WIDTH-1:0]            redirect_pc,
    output logic                        ifid_valid,
    output logic [INSTRUCTIONWIDTH-1:0] ifid_instr,
    output logic [WIDTH-1:0]            ifid_pc,
    output logic [WIDTH-1:0]            ifid_pc_next,
    output logic                        fetch_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]                 perf_fetched,
    output logic [15:0]                 perf_stalls
`endif
);

    localparam int unsigned LAST_PC   = IMEM_BYTES - PC_STEP;
    localparam int unsigned PERF_W    = 16;

    logic [WIDTH-1:0]            pc_q, pc_d;
    logic                        valid_q, valid_d;
    logic [INSTRUCTIONWIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0]            ipc_q, ipc_d;
    logic [WIDTH-1:0]            ipc_next_q, ipc_next_d;
    logic                        fault_q, fault_d;
    logic                        out_of_range_c;
    logic                        fetch_c;
    logic                        stall_cnt_c;
    logic [WIDTH-1:0]            pc_inc_c;

    // Misaligned PC or a PC whose instruction would spill past the segment.
    assign out_of_range_c = pc_q[0] || (32'(pc_q) > LAST_PC);
    assign pc_inc_c       = pc_q + WIDTH'(PC_STEP);

    always_comb begin
        pc_d        = pc_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        ipc_d       = ipc_q;
        ipc_next_d  = ipc_next_q;
        fault_d     = fault_q;
        fetch_c     = 1'b0;
        stall_cnt_c = 1'b0;
        if (!fault_q) begin
            if (redirect) begin
                pc_d    = redirect_pc;
                valid_d = 1'b0;
            end else if (stall) begin
                stall_cnt_c = 1'b1;
            end else if (out_of_range_c) begin
                fault_d = 1'b1;
                valid_d = 1'b0;
            end else begin
                fetch_c    = 1'b1;
                valid_d    = 1'b1;
                instr_d    = imem_rdata;
                ipc_d      = pc_q;
                ipc_next_d = pc_inc_c;
                pc_d       = pc_inc_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= WIDTH'(RESET_PC);
            valid_q    <= 1'b0;
            instr_q    <= '0;
            ipc_q      <= '0;
            ipc_next_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            ipc_next_q <= ipc_next_d;
            fault_q    <= fault_d;
        end
    end

    assign imem_addr    = pc_q;
    assign ifid_valid   = valid_q;
    assign ifid_instr   = instr_q;
    assign ifid_pc      = ipc_q;
    assign ifid_pc_next = ipc_next_q;
    assign fetch_fault  = fault_q;

`ifdef FETCH_PERF_EN
    logic [PERF_W-1:0] fetched_q, fetched_d;
    logic [PERF_W-1:0] stalls_q, stalls_d;

    // Saturating event counters.
    always_comb begin
        fetched_d = fetched_q;
        stalls_d  = stalls_q;
        if (fetch_c && (fetched_q != {PERF_W{1'b1}})) begin
            fetched_d = fetched_q + PERF_W'(1);
        end
        if (stall_cnt_c && (stalls_q != {PERF_W{1'b1}})) begin
            stalls_d = stalls_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            fetched_q <= fetched_d;
            stalls_q  <= stalls_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
`else
    logic unused_perf_c;
    assign unused_perf_c = fetch_c ^ stall_cnt_c ^ (PERF_W != 0);
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized stall/redirect/reset
// traffic, checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int unsigned W    = 8;
    localparam int unsigned IW   = 24;
    localparam int unsigned STEP = 2;
    localparam int unsigned IMB  = 32;
    localparam int unsigned RPC  = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [W-1:0]  redirect_pc = '0;
    logic          ifid_valid;
    logic [IW-1:0] ifid_instr;
    logic [W-1:0]  ifid_pc;
    logic [W-1:0]  ifid_pc_next;
    logic          fetch_fault;
`ifdef FETCH_PERF_EN
    logic [15:0]   perf_fetched;
    logic [15:0]   perf_stalls;
`endif

    logic [IW-1:0] mem [256];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int unsigned   m_pc;
    bit            m_valid;
    logic [IW-1:0] m_instr;
    int unsigned   m_ipc;
    int unsigned   m_ipc_next;
    bit            m_fault;
    int unsigned   m_fetched;
    int unsigned   m_stalls;

    fetch_stage #(
        .WIDTH(W), .INSTRUCTIONWIDTH(IW), .PC_STEP(STEP),
        .IMEM_BYTES(IMB), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_pc_next(ifid_pc_next),
        .fetch_fault(fetch_fault)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":imem_addr"}, 32'(imem_addr), m_pc % 256);
        chk({ctx, ":valid"}, 32'(ifid_valid), 32'(m_valid));
        chk({ctx, ":instr"}, 32'(ifid_instr), 32'(m_instr));
        chk({ctx, ":ifid_pc"}, 32'(ifid_pc), m_ipc);
        chk({ctx, ":ifid_pc_next"}, 32'(ifid_pc_next), m_ipc_next);
        chk({ctx, ":fault"}, 32'(fetch_fault), 32'(m_fault));
`ifdef FETCH_PERF_EN
        chk({ctx, ":perf_fetched"}, 32'(perf_fetched), m_fetched);
        chk({ctx, ":perf_stalls"}, 32'(perf_stalls), m_stalls);
`endif
    endtask

    function automatic void model_reset();
        m_pc = RPC; m_valid = 0; m_instr = '0; m_ipc = 0; m_ipc_next = 0;
        m_fault = 0; m_fetched = 0; m_stalls = 0;
    endfunction

    // One rising edge as described by the priority rules, using arithmetic mod 256.
    function automatic void model_edge(input bit st, input bit rd, input int unsigned rpc);
        if (m_fault) return;
        if (rd) begin
            m_pc = rpc;
            m_valid = 0;
        end else if (st) begin
            if (m_stalls < 65535) m_stalls++;
        end else if ((m_pc % 2 != 0) || (m_pc + STEP > IMB)) begin
            m_fault = 1;
            m_valid = 0;
        end else begin
            m_valid = 1;
            m_instr = mem[m_pc];
            m_ipc = m_pc;
            m_ipc_next = (m_pc + STEP) % 256;
            m_pc = (m_pc + STEP) % 256;
            if (m_fetched < 65535) m_fetched++;
        end
    endfunction

    // Apply inputs away from the edge, clock once, then compare #1 after the edge.
    task automatic cycle(input bit st, input bit rd, input logic [W-1:0] rpc, input string ctx);
        stall = st; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        model_edge(st, rd, 32'(rpc));
        #1;
        check_all(ctx);
    endtask

    task automatic do_reset(input string ctx);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(ctx);
        stall = 1'b0; redirect = 1'b0;
        @(posedge clk);
        #1;
        check_all({ctx, "_held"});
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
        mem[0] = 24'h001234;
        mem[2] = 24'h005678;
        model_reset();

        #2;
        do_reset("reset");

        cycle(0, 0, '0, "fetch0");
        chk("fetch0_instr_const", 32'(ifid_instr), 32'h001234);
        cycle(0, 0, '0, "fetch2");
        chk("fetch2_instr_const", 32'(ifid_instr), 32'h005678);
        chk("fetch2_addr_const", 32'(imem_addr), 32'd4);

        for (int i = 0; i < 3; i++) cycle(1, 0, '0, "stall3");
        cycle(0, 0, '0, "after_stall");
        chk("after_stall_pc", 32'(ifid_pc), 32'd4);

        cycle(1, 1, 8'h10, "redir_stall");
        chk("redir_bubble", 32'(ifid_valid), 32'd0);
        cycle(0, 0, '0, "redir_target");
        chk("redir_target_pc", 32'(ifid_pc), 32'h10);

        guard = 0;
        while (!m_fault && guard < 40) begin
            cycle(0, 0, '0, "seq_run");
            guard++;
        end
        chk("seq_run_faulted_in_budget", 32'(guard < 40), 32'd1);
        chk("seq_fault_addr", 32'(imem_addr), 32'd32);
        cycle(0, 1, 8'h00, "redir_ignored");

        do_reset("reset2");
        cycle(0, 1, 8'h05, "redir_odd");
        chk("redir_odd_addr", 32'(imem_addr), 32'd5);
        cycle(0, 0, '0, "odd_fault");
        chk("odd_fault_flag", 32'(fetch_fault), 32'd1);
        @(negedge clk);
        do_reset("reset_async");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            bit st, rd;
            logic [W-1:0] rpc;
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) rpc = W'($urandom);
            else rpc = W'($urandom_range(0, 15) * 2);
            if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
                do_reset("rand_reset");
            else
                cycle(st, rd, rpc, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
